// File: rtl/sprite_pkg.sv
// Shared constants for the sprite palette fetcher: FSM encodings, Avalon byte-enable, cache bounds.
package sprite_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t S_IDLE  = 2'd0;
    localparam fsm_state_t S_FETCH = 2'd1;
    localparam fsm_state_t S_DRAIN = 2'd2;

    localparam logic [3:0] BE_ALL        = 4'hF;
    localparam int         PAL_DEPTH_MAX = 64;

endpackage

// File: rtl/sprite_palette_regfile.sv
// Palette cache: one write port, one registered read port (read-before-write), async clear.
module sprite_palette_regfile
    import sprite_pkg::*;
#(
    parameter int DEPTH  = PAL_DEPTH_MAX,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports use non-blocking updates, so a same-cycle read sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sprite_palette_fetcher.sv
// Avalon-MM read master that burst-loads the sprite palette into a local cache and serves lookups.
// Optional PALETTE_CHECKSUM_EN adds a pal_checksum output summing every cached word.
module sprite_palette_fetcher
    import sprite_pkg::*;
#(
    parameter int PAL_DEPTH = 64,
    parameter int ADDR_W    = 6,
    parameter int MAX_PEND  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              pix_valid,
    input  logic [ADDR_W-1:0] pix_index,
    output logic              col_valid,
    output logic [31:0]       col_data
`ifdef PALETTE_CHECKSUM_EN
    ,
    output logic [31:0]       pal_checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAL_DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(PAL_DEPTH);
    localparam logic [2:0]        PEND_CAP  = 3'(MAX_PEND);

    fsm_state_t        state;
    logic [ADDR_W-1:0] issue_cnt;
    logic [ADDR_W:0]   recv_cnt;
    logic [2:0]        pend;

    logic start_ok, accept, rdv_ok, drain_done;

    assign start_ok   = (state == S_IDLE) && start;
    assign accept     = avm_read && !avm_waitrequest;
    // Returns with nothing outstanding (or after reset) are strays and must not touch the cache.
    assign rdv_ok     = avm_readdatavalid && (state != S_IDLE) && (pend != 3'd0);
    assign drain_done = (state == S_DRAIN) && (recv_cnt == FULL_CNT);

    assign avm_read       = (state == S_FETCH) && (pend < PEND_CAP);
    assign avm_address    = issue_cnt;
    assign avm_byteenable = BE_ALL;
    assign busy           = (state != S_IDLE);
    assign done           = drain_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_FETCH;
                    issue_cnt <= '0;
                end
                S_FETCH: if (accept) begin
                    if (issue_cnt == LAST_ADDR) state <= S_DRAIN;
                    else                        issue_cnt <= issue_cnt + ADDR_W'(1);
                end
                S_DRAIN: if (drain_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recv_cnt <= '0;
            pend     <= '0;
        end else begin
            if (start_ok)    recv_cnt <= '0;
            else if (rdv_ok) recv_cnt <= recv_cnt + (ADDR_W + 1)'(1);
            case ({accept, rdv_ok})
                2'b10:   pend <= pend + 3'd1;
                2'b01:   pend <= pend - 3'd1;
                default: pend <= pend;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) col_valid <= 1'b0;
        else       col_valid <= pix_valid;
    end

    sprite_palette_regfile #(
        .DEPTH  (PAL_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_cache (
        .clk   (clk),
        .rst   (reset),
        .we    (rdv_ok),
        .waddr (recv_cnt[ADDR_W-1:0]),
        .wdata (avm_readdata),
        .re    (pix_valid),
        .raddr (pix_index),
        .rdata (col_data)
    );

`ifdef PALETTE_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         pal_checksum <= '0;
        else if (start_ok) pal_checksum <= '0;
        else if (rdv_ok)   pal_checksum <= pal_checksum + avm_readdata;
    end
`endif

endmodule
